// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed 7-segment bus, waits for each pattern to settle, and
// decodes it back into a per-digit register file of hex nibbles.
module seg7_capture_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  frame_strobe,
  output logic                  error
);

  localparam int SW = 7 + DIGITS;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]       r_s1;
  logic [SW-1:0]       r_s2;
  logic [SW-1:0]       r_p;
  logic [CW-1:0]       r_cnt;
  logic                r_armed;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_digit_valid;
  logic                r_frame_strobe;
  logic                r_error;

  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_dig;
  logic                w_capture;
  logic                w_blank;
  logic                w_onehot;
  logic [4:0]          w_decoded;
  logic                w_legal;
  logic [3:0]          w_nibble;
  logic [4*DIGITS-1:0] w_value_nxt;
  logic [DIGITS-1:0]   w_valid_nxt;
  logic                w_error_nxt;
  logic                w_strobe_nxt;

  // Returns {legal, nibble}; only the canonical glyph of each digit is accepted.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] d;
    d = 5'd0;
    case (s)
      7'h3F: d = {1'b1, 4'h0};
      7'h06: d = {1'b1, 4'h1};
      7'h5B: d = {1'b1, 4'h2};
      7'h4F: d = {1'b1, 4'h3};
      7'h66: d = {1'b1, 4'h4};
      7'h6D: d = {1'b1, 4'h5};
      7'h7D: d = {1'b1, 4'h6};
      7'h07: d = {1'b1, 4'h7};
      7'h7F: d = {1'b1, 4'h8};
      7'h67: d = {1'b1, 4'h9};
      7'h77: d = {1'b1, 4'hA};
      7'h7C: d = {1'b1, 4'hB};
      7'h39: d = {1'b1, 4'hC};
      7'h5E: d = {1'b1, 4'hD};
      7'h79: d = {1'b1, 4'hE};
      7'h71: d = {1'b1, 4'hF};
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  assign w_seg     = r_s2[SW-1 -: 7];
  assign w_dig     = r_s2[DIGITS-1:0];
  assign w_capture = (r_s2 == r_p) && (r_cnt == CNT_MAX) && r_armed;
  assign w_blank   = (w_dig == '0);
  assign w_onehot  = !w_blank && ((w_dig & (w_dig - DIGITS'(1))) == '0);
  assign w_decoded = decode_seg(w_seg);
  assign w_legal   = w_decoded[4];
  assign w_nibble  = w_decoded[3:0];

  // Synchronizer, previous-sample register and settle counter. armed drops
  // after one capture so a held pattern is taken only once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_s1 <= {seg, dig_en};
      r_s2 <= r_s1;
      r_p  <= r_s2;
      if (r_s2 != r_p) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_armed) begin
        r_armed <= 1'b0;
      end
    end
  end

  always_comb begin
    w_value_nxt  = r_value;
    w_valid_nxt  = r_digit_valid;
    w_error_nxt  = 1'b0;
    w_strobe_nxt = 1'b0;
    if (w_capture && !w_blank) begin
      if (!w_onehot) begin
        w_error_nxt = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_dig[i]) begin
            if (w_seg == 7'h00) begin
              w_valid_nxt[i] = 1'b0;
            end else if (w_legal) begin
              w_value_nxt[4*i +: 4] = w_nibble;
              w_valid_nxt[i]        = 1'b1;
            end else begin
              w_valid_nxt[i] = 1'b0;
              w_error_nxt    = 1'b1;
            end
          end
        end
        // Frame completes when the last digit lands and every digit is valid.
        w_strobe_nxt = w_legal && w_dig[DIGITS-1] && (&w_valid_nxt);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_value        <= '0;
      r_digit_valid  <= '0;
      r_frame_strobe <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_value        <= w_value_nxt;
      r_digit_valid  <= w_valid_nxt;
      r_frame_strobe <= w_strobe_nxt;
      r_error        <= w_error_nxt;
    end
  end

  assign value        = r_value;
  assign digit_valid  = r_digit_valid;
  assign frame_valid  = &r_digit_valid;
  assign frame_strobe = r_frame_strobe;
  assign error        = r_error;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed scenarios plus random holds, each
// hold scored against a transaction-level model of the decoder.
module tb_seg7_capture_decoder;

  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        frame_strobe;
  logic        error;

  always #5 clk = ~clk;

  seg7_capture_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .CLK          (clk),
    .RST          (rst),
    .seg          (seg),
    .dig_en       (dig_en),
    .value        (value),
    .digit_valid  (digit_valid),
    .frame_valid  (frame_valid),
    .frame_strobe (frame_strobe),
    .error        (error)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  valid;
    logic [7:0]  n_strobe;
    logic [7:0]  n_err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_value;
  logic [3:0]  m_valid;
  int          tests = 0;
  int          fails = 0;

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected effect of one settled pattern on the register file.
  task automatic model_apply(input logic [6:0] s, input logic [3:0] d, output exp_t e);
    int         idx;
    bit         hit;
    logic [3:0] nib;
    logic [7:0] ps;
    logic [7:0] pe;
    idx = 0; hit = 0; nib = 4'h0; ps = 8'd0; pe = 8'd0;
    if (d == 4'b0000) begin
      ps = 8'd0;
    end else if ($countones(d) != 1) begin
      pe = 8'd1;
    end else begin
      for (int k = 0; k < 4; k++) if (d[k]) idx = k;
      for (int k = 0; k < 16; k++) if (codes[k] == s) begin hit = 1; nib = 4'(k); end
      if (s == 7'h00) begin
        m_valid[idx] = 1'b0;
      end else if (hit) begin
        m_value[4*idx +: 4] = nib;
        m_valid[idx] = 1'b1;
        if (idx == 3 && m_valid == 4'hF) ps = 8'd1;
      end else begin
        m_valid[idx] = 1'b0;
        pe = 8'd1;
      end
    end
    e.value = m_value; e.valid = m_valid; e.n_strobe = ps; e.n_err = pe;
  endtask

  // Drive a pattern for cyc cycles starting at a negedge; settle=0 marks a
  // glitch too short to be captured.
  task automatic hold(input string tag, input logic [6:0] s, input logic [3:0] d,
                      input int cyc, input bit settle);
    exp_t        e;
    logic [15:0] v0;
    logic [3:0]  q0;
    logic [21:0] start;
    int          lat, ns, ne, nb, exp_lat;
    v0 = m_value; q0 = m_valid;
    seg = s; dig_en = d;
    if (settle) model_apply(s, d, e);
    else e = '{m_value, m_valid, 8'd0, 8'd0};
    exp_q.push_back(e);
    start = {v0, q0, 2'b00};
    lat = 0; ns = 0; ne = 0; nb = 0;
    for (int i = 1; i <= cyc; i++) begin
      @(posedge clk); #1;
      if (frame_strobe) ns++;
      if (error) ne++;
      if (frame_strobe && error) nb++;
      if (lat == 0 && {value, digit_valid, frame_strobe, error} != start) lat = i;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    exp_lat = ((e.value != v0) || (e.valid != q0) || (e.n_strobe != 0) || (e.n_err != 0)) ? LAT : 0;
    check({tag, ".value"},   32'(value),        32'(e.value));
    check({tag, ".valid"},   32'(digit_valid),  32'(e.valid));
    check({tag, ".frame"},   32'(frame_valid),  32'(&e.valid));
    check({tag, ".strobes"}, 32'(ns),           32'(e.n_strobe));
    check({tag, ".errors"},  32'(ne),           32'(e.n_err));
    check({tag, ".both"},    32'(nb),           32'(0));
    check({tag, ".latency"}, 32'(lat),          32'(exp_lat));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".value"},  32'(value),        32'(0));
    check({tag, ".valid"},  32'(digit_valid),  32'(0));
    check({tag, ".frame"},  32'(frame_valid),  32'(0));
    check({tag, ".strobe"}, 32'(frame_strobe), 32'(0));
    check({tag, ".error"},  32'(error),        32'(0));
  endtask

  initial begin
    rst = 1'b1; seg = 7'h00; dig_en = 4'b0000;
    m_value = 16'h0; m_valid = 4'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    hold("first_2", 7'h5B, 4'b0001, 30, 1);

    hold("scan_d0", 7'h06, 4'b0001, 10, 1);
    hold("scan_d1", 7'h4F, 4'b0010, 10, 1);
    hold("scan_d2", 7'h66, 4'b0100, 10, 1);
    hold("scan_d3", 7'h71, 4'b1000, 10, 1);
    check("scan_word", 32'(value), 32'h0000F431);

    hold("glitch_a", 7'h7F, 4'b0010, 3, 0);
    hold("after_a",  7'h06, 4'b0010, 10, 1);
    hold("glitch_b", 7'h7F, 4'b0010, 3, 0);
    hold("after_b",  7'h5B, 4'b0010, 10, 1);
    hold("restore1", 7'h06, 4'b0010, 10, 1);

    hold("bad_code", 7'h6F, 4'b0100, 10, 1);
    hold("two_hot",  7'h06, 4'b0011, 10, 1);

    hold("d0_zero",  7'h3F, 4'b0001, 10, 1);
    hold("d0_blank", 7'h00, 4'b0001, 10, 1);
    hold("no_dig",   7'h00, 4'b0000, 10, 1);

    hold("fr_d0", 7'h79, 4'b0001, 10, 1);
    hold("fr_d1", 7'h5E, 4'b0010, 10, 1);
    hold("fr_d2", 7'h39, 4'b0100, 10, 1);
    hold("fr_d3", 7'h7C, 4'b1000, 10, 1);
    hold("fr_re", 7'h77, 4'b1000, 10, 1);
    hold("idle",  7'h00, 4'b0000, 10, 1);

    // Reset lands on the fifth edge of a settle that would otherwise capture.
    seg = 7'h6D; dig_en = 4'b0010;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");
    m_value = 16'h0; m_valid = 4'h0;
    hold("rst_release", 7'h6D, 4'b0010, 10, 1);

    for (int n = 0; n < 24; n++) begin
      logic [6:0] s;
      logic [3:0] d;
      int         r;
      do begin
        r = $urandom_range(0, 9);
        d = (r < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        if (r < 6)      s = codes[$urandom_range(0, 15)];
        else if (r < 8) s = 7'h00;
        else            s = 7'($urandom_range(0, 127));
      end while ({s, d} == {seg, dig_en});
      if ($urandom_range(0, 3) == 0) hold("rnd_glitch", s, d, $urandom_range(1, 3), 0);
      else                           hold("rnd", s, d, $urandom_range(8, 12), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
